// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the VGA framebuffer write-port arbiter.
package draw_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StOwn,
    StGap
  } arb_state_e;

  localparam int unsigned REQ_SCROLL = 0;
  localparam int unsigned REQ_PLAYER = 1;
  localparam int unsigned REQ_SCORE  = 2;

  localparam int unsigned DefNReq    = 3;
  localparam int unsigned DefXW      = 8;
  localparam int unsigned DefYW      = 7;
  localparam int unsigned DefColourW = 3;
  localparam int unsigned DefMaxHold = 4096;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Requester-side and framebuffer-side signals of the draw arbiter.
interface vga_draw_arbiter_if import draw_arb_pkg::*; #(
  parameter int unsigned N_REQ    = DefNReq,
  parameter int unsigned X_W      = DefXW,
  parameter int unsigned Y_W      = DefYW,
  parameter int unsigned COLOUR_W = DefColourW
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*X_W-1:0]      req_x;
  logic [N_REQ*Y_W-1:0]      req_y;
  logic [N_REQ*COLOUR_W-1:0] req_colour;
  logic [N_REQ-1:0]          req_plot;
  logic [N_REQ-1:0]          req_last;
  logic                      beat_pulse;
  logic [N_REQ-1:0]          grant;
  logic [X_W-1:0]            vga_x;
  logic [Y_W-1:0]            vga_y;
  logic [COLOUR_W-1:0]       vga_colour;
  logic                      vga_plot;
  logic                      busy;
  logic                      timeout;

  modport master (
    output req, req_x, req_y, req_colour, req_plot, req_last, beat_pulse,
    input  grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
  );

  modport slave (
    input  req, req_x, req_y, req_colour, req_plot, req_last, beat_pulse,
    output grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin winner select with a priority boost for the scroll requester.
module rr_picker import draw_arb_pkg::*; #(
  parameter int unsigned N_REQ = DefNReq,
  localparam int unsigned IdxW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  rr_ptr_i,
  input  logic             boost_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] winner_o,
  output logic [IdxW-1:0]  winner_idx_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    valid_o      = 1'b0;
    winner_o     = '0;
    winner_idx_o = '0;
    sum          = '0;
    cand         = '0;
    if (boost_i && req_i[REQ_SCROLL]) begin
      valid_o              = 1'b1;
      winner_o[REQ_SCROLL] = 1'b1;
      winner_idx_o         = IdxW'(REQ_SCROLL);
    end else begin
      // Scan from rr_ptr upward, wrapping; first requester found wins.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        sum = {1'b0, rr_ptr_i} + (IdxW+1)'(i);
        if (sum >= (IdxW+1)'(N_REQ)) sum = sum - (IdxW+1)'(N_REQ);
        cand = sum[IdxW-1:0];
        if (!valid_o && req_i[cand]) begin
          valid_o        = 1'b1;
          winner_o[cand] = 1'b1;
          winner_idx_o   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Burst arbiter for the single VGA framebuffer write port; registered pixel output.
// Optional hold watchdog enabled by defining ARB_WATCHDOG_EN.
module vga_draw_arbiter import draw_arb_pkg::*; #(
  parameter int unsigned N_REQ    = DefNReq,
  parameter int unsigned X_W      = DefXW,
  parameter int unsigned Y_W      = DefYW,
  parameter int unsigned COLOUR_W = DefColourW,
  parameter int unsigned MAX_HOLD = DefMaxHold
) (
  input logic               clock,
  input logic               reset,
  vga_draw_arbiter_if.slave bus
);

  localparam int unsigned IdxW = idx_width(N_REQ);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                beat_pending_q, beat_pending_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;

  logic                pick_valid;
  logic [N_REQ-1:0]    pick_grant;
  logic [IdxW-1:0]     pick_idx;
  logic                hold_expired;

  logic [X_W-1:0]      req_x_arr      [N_REQ];
  logic [Y_W-1:0]      req_y_arr      [N_REQ];
  logic [COLOUR_W-1:0] req_colour_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_x_arr[g]      = bus.req_x[g*X_W +: X_W];
    assign req_y_arr[g]      = bus.req_y[g*Y_W +: Y_W];
    assign req_colour_arr[g] = bus.req_colour[g*COLOUR_W +: COLOUR_W];
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i        (bus.req),
    .rr_ptr_i     (rr_ptr_q),
    .boost_i      (beat_pending_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_grant),
    .winner_idx_o (pick_idx)
  );

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned HoldW = ($clog2(MAX_HOLD + 1) > 13) ? $clog2(MAX_HOLD + 1) : 13;

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == StArb) begin
      hold_cnt_d = '0;
    end else if (state_q == StOwn) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
  end

  assign hold_expired = (state_q == StOwn) && (hold_cnt_q == HoldW'(MAX_HOLD - 1));

  always_ff @(posedge clock) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign hold_expired    = 1'b0;
`endif

  logic own_req, own_plot, own_last, own_done, own_forced;

  assign own_req    = bus.req[owner_q];
  assign own_plot   = bus.req_plot[owner_q];
  assign own_last   = bus.req_last[owner_q];
  assign own_done   = own_req && own_plot && own_last;
  // A natural final pixel on the expiry edge wins over the watchdog.
  assign own_forced = hold_expired && own_req && !own_done;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    busy_d         = busy_q;
    timeout_d      = 1'b0;
    vga_x_d        = vga_x_q;
    vga_y_d        = vga_y_q;
    vga_colour_d   = vga_colour_q;
    vga_plot_d     = 1'b0;
    beat_pending_d = beat_pending_q | bus.beat_pulse;

    unique case (state_q)
      StIdle: begin
        if (|bus.req) state_d = StArb;
      end
      StArb: begin
        if (pick_valid) begin
          state_d = StOwn;
          grant_d = pick_grant;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          // A beat arriving with the scroll grant stays pending for the next beat.
          if (pick_grant[REQ_SCROLL] && !bus.beat_pulse) beat_pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StOwn: begin
        vga_x_d      = req_x_arr[owner_q];
        vga_y_d      = req_y_arr[owner_q];
        vga_colour_d = req_colour_arr[owner_q];
        vga_plot_d   = own_req && own_plot && !own_forced;
        if (!own_req || own_done || own_forced) begin
          state_d   = StGap;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = own_forced;
          rr_ptr_d  = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      grant_q        <= '0;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      beat_pending_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      vga_x_q        <= '0;
      vga_y_q        <= '0;
      vga_colour_q   <= '0;
      vga_plot_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      beat_pending_q <= beat_pending_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
      vga_x_q        <= vga_x_d;
      vga_y_q        <= vga_y_d;
      vga_colour_q   <= vga_colour_d;
      vga_plot_q     <= vga_plot_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: burst ownership, round robin, beat boost, reset, watchdog.
module tb_vga_draw_arbiter;

  localparam int unsigned NReq    = 3;
  localparam int unsigned XW      = 8;
  localparam int unsigned YW      = 7;
  localparam int unsigned CW      = 3;
  localparam int unsigned MaxHold = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  vga_draw_arbiter_if #(
    .N_REQ    (NReq),
    .X_W      (XW),
    .Y_W      (YW),
    .COLOUR_W (CW)
  ) bus ();

  vga_draw_arbiter #(
    .N_REQ    (NReq),
    .X_W      (XW),
    .Y_W      (YW),
    .COLOUR_W (CW),
    .MAX_HOLD (MaxHold)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [XW-1:0]   tx [NReq];
  logic [YW-1:0]   ty [NReq];
  logic [CW-1:0]   tc [NReq];
  logic [NReq-1:0] tplot;
  logic [NReq-1:0] tlast;

  assign bus.req_x      = {tx[2], tx[1], tx[0]};
  assign bus.req_y      = {ty[2], ty[1], ty[0]};
  assign bus.req_colour = {tc[2], tc[1], tc[0]};
  assign bus.req_plot   = tplot;
  assign bus.req_last   = tlast;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input logic [1:0] i, input int x, input int y, input int c,
                         input logic plot, input logic last);
    tx[i]    = XW'(x);
    ty[i]    = YW'(y);
    tc[i]    = CW'(c);
    tplot[i] = plot;
    tlast[i] = last;
  endtask

  task automatic clear_inputs();
    for (int g = 0; g < 3; g++) set_pix(2'(g), 0, 0, 0, 1'b0, 1'b0);
    bus.req        = '0;
    bus.beat_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input logic [2:0] exp, input string tag);
    int k;
    k = 0;
    while (bus.grant == '0 && k < 10) begin
      step();
      k++;
    end
    check(tag, 32'(bus.grant), 32'(exp));
  endtask

  // Owner idx writes npx pixels, last flagged on the final one.
  task automatic burst(input logic [1:0] idx, input int npx, input string tag);
    int ex;
    for (int p = 0; p < npx; p++) begin
      ex = 16 * int'(idx) + p + 1;
      set_pix(idx, ex, p, int'(idx), 1'b1, p == npx - 1);
      step();
      check({tag, "_plot"}, 32'(bus.vga_plot), 32'd1);
      check({tag, "_x"}, 32'(bus.vga_x), 32'(ex));
    end
    set_pix(idx, 0, 0, 0, 1'b0, 1'b0);
    check({tag, "_released"}, 32'(bus.grant), 32'd0);
  endtask

  logic [2:0] t2_exp [4];
  logic [1:0] t2_idx [4];
  int         held;
  logic       seen_to;

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_plot", 32'(bus.vga_plot), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_x", 32'(bus.vga_x), 32'd0);
    check("rst_y", 32'(bus.vga_y), 32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);
    reset = 1'b0;
    step();
    step();
    step();
    check("idle_grant", 32'(bus.grant), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Single requester, 4-pixel burst
    bus.req = 3'b010;
    step();
    check("t1_arb_grant", 32'(bus.grant), 32'd0);
    step();
    check("t1_grant", 32'(bus.grant), 32'h2);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_no_plot_yet", 32'(bus.vga_plot), 32'd0);
    for (int k = 0; k < 4; k++) begin
      set_pix(2'd1, 10 + k, 20 + k, 5, 1'b1, k == 3);
      step();
      check("t1_plot", 32'(bus.vga_plot), 32'd1);
      check("t1_x", 32'(bus.vga_x), 32'(10 + k));
    end
    check("t1_y", 32'(bus.vga_y), 32'd23);
    check("t1_colour", 32'(bus.vga_colour), 32'd5);
    check("t1_release_grant", 32'(bus.grant), 32'd0);
    check("t1_release_busy", 32'(bus.busy), 32'd0);
    bus.req = '0;
    set_pix(2'd1, 0, 0, 0, 1'b0, 1'b0);
    step();
    check("t1_gap_plot", 32'(bus.vga_plot), 32'd0);
    step();

    // All three requesting: rotation from rr_ptr=0
    do_reset();
    t2_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    t2_idx = '{2'd0, 2'd1, 2'd2, 2'd0};
    bus.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_grant(t2_exp[g], "t2_grant");
      burst(t2_idx[g], 2, "t2_burst");
      step();
      check("t2_gap_grant", 32'(bus.grant), 32'd0);
    end
    bus.req = '0;
    step();
    step();
    step();

    // Beat boost lifts scroll ahead of score
    do_reset();
    bus.req        = 3'b110;
    bus.beat_pulse = 1'b1;
    step();
    bus.beat_pulse = 1'b0;
    step();
    check("t3_grant_player", 32'(bus.grant), 32'h2);
    bus.req = 3'b111;
    set_pix(2'd1, 1, 1, 1, 1'b1, 1'b1);
    step();
    check("t3_release", 32'(bus.grant), 32'd0);
    set_pix(2'd1, 0, 0, 0, 1'b0, 1'b0);
    wait_grant(3'b001, "t3_boost_grant");

    // Non-granted plots are ignored
    set_pix(2'd0, 3, 4, 6, 1'b1, 1'b0);
    set_pix(2'd2, 5, 9, 1, 1'b1, 1'b0);
    step();
    check("t4_own_plot", 32'(bus.vga_plot), 32'd1);
    check("t4_own_x", 32'(bus.vga_x), 32'd3);
    check("t4_own_y", 32'(bus.vga_y), 32'd4);
    set_pix(2'd0, 3, 4, 6, 1'b0, 1'b0);
    step();
    check("t4_ignore_plot", 32'(bus.vga_plot), 32'd0);
    check("t4_ignore_x", 32'(bus.vga_x), 32'd3);
    set_pix(2'd0, 7, 8, 2, 1'b1, 1'b1);
    step();
    check("t4_last_plot", 32'(bus.vga_plot), 32'd1);
    check("t4_last_x", 32'(bus.vga_x), 32'd7);
    check("t4_last_release", 32'(bus.grant), 32'd0);
    set_pix(2'd0, 0, 0, 0, 1'b0, 1'b0);
    set_pix(2'd2, 0, 0, 0, 1'b0, 1'b0);
    wait_grant(3'b010, "t3_pending_cleared");

    // Reset two cycles into a burst
    set_pix(2'd1, 40, 41, 3, 1'b1, 1'b0);
    step();
    step();
    check("t5_mid_plot", 32'(bus.vga_plot), 32'd1);
    reset = 1'b1;
    step();
    check("t5_rst_grant", 32'(bus.grant), 32'd0);
    check("t5_rst_plot", 32'(bus.vga_plot), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_x", 32'(bus.vga_x), 32'd0);
    reset = 1'b0;
    set_pix(2'd1, 0, 0, 0, 1'b0, 1'b0);
    wait_grant(3'b001, "t5_rrptr_reset");

    // Dropping req releases with no write even if plot+last are high
    bus.req = 3'b110;
    set_pix(2'd0, 50, 50, 1, 1'b1, 1'b1);
    step();
    check("drop_grant", 32'(bus.grant), 32'd0);
    check("drop_no_write", 32'(bus.vga_plot), 32'd0);
    set_pix(2'd0, 0, 0, 0, 1'b0, 1'b0);
    bus.req = '0;
    step();
    step();
    step();

`ifdef ARB_WATCHDOG_EN
    do_reset();
    bus.req = 3'b110;
    wait_grant(3'b010, "t6_grant");
    held = 0;
    while (bus.grant == 3'b010 && held < 20) begin
      step();
      held++;
    end
    check("t6_hold_cycles", 32'(held), 32'(MaxHold));
    check("t6_timeout_pulse", 32'(bus.timeout), 32'd1);
    step();
    check("t6_timeout_clear", 32'(bus.timeout), 32'd0);
    wait_grant(3'b100, "t6_next_grant");
`else
    do_reset();
    bus.req = 3'b010;
    wait_grant(3'b010, "t6_grant");
    seen_to = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen_to = seen_to | bus.timeout;
    end
    check("t6_still_held", 32'(bus.grant), 32'h2);
    check("t6_no_timeout", 32'(seen_to), 32'd0);
`endif
    bus.req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout, expected completion");
    $fatal(1, "time limit");
  end

endmodule
